// File: rtl/reg_cmd_pkg.sv
// Shared types and default constants for the register-file command sequencer.
package reg_cmd_pkg;

  localparam int         ADDR_W_DEF      = 4;
  localparam int         DATA_W_DEF      = 8;
  localparam logic [7:0] CMD_WR_DEF      = 8'hAA;
  localparam logic [7:0] CMD_RD_DEF      = 8'hBB;
  localparam int         TIMEOUT_CYC_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_HOLD
  } state_e;

endpackage

// File: rtl/reg_cmd_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module reg_cmd_timeout #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command sequencer driving the 16x8 register file and returning read data to TX.
// Optional read-wait timeout is enabled by defining RD_TIMEOUT_EN.
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int               ADDR_W = ADDR_W_DEF,
  parameter int               DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] CMD_WR = CMD_WR_DEF,
  parameter logic [DATA_W-1:0] CMD_RD = CMD_RD_DEF
`ifdef RD_TIMEOUT_EN
  , parameter int             TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_rd_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err_timeout
);

  state_e state_q;
  state_e state_d;

  logic              rf_wr_en_q,   rf_wr_en_d;
  logic              rf_rd_en_q,   rf_rd_en_d;
  logic [ADDR_W-1:0] rf_addr_q,    rf_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic [DATA_W-1:0] tx_data_q,    tx_data_d;
  logic              tx_valid_q,   tx_valid_d;
  logic              busy_q,       busy_d;
  logic              rd_expired;

`ifdef RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic err_timeout_q, err_timeout_d;
  logic rd_load;
  logic rd_count_en;

  // Counter is reloaded on the same edge that enters RD_WAIT.
  assign rd_load     = (state_q == RD_ADDR) && rx_valid;
  assign rd_count_en = (state_q == RD_WAIT);

  reg_cmd_timeout #(
    .CNT_W(CNT_W)
  ) u_timeout (
    .clk      (CLK),
    .rst      (RST),
    .load     (rd_load),
    .load_val (CNT_W'(TIMEOUT_CYC - 1)),
    .en       (rd_count_en),
    .expired  (rd_expired)
  );
`else
  assign rd_expired = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == CMD_WR)) begin
          state_d = WR_ADDR;
        end else if (rx_valid && (rx_data == CMD_RD)) begin
          state_d = RD_ADDR;
        end
      end
      WR_ADDR: if (rx_valid) state_d = WR_DATA;
      WR_DATA: if (rx_valid) state_d = IDLE;
      RD_ADDR: if (rx_valid) state_d = RD_WAIT;
      RD_WAIT: begin
        if (rf_rd_valid) begin
          state_d = TX_HOLD;
        end else if (rd_expired) begin
          state_d = IDLE;
        end
      end
      TX_HOLD: if (tx_valid_q && tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bytes arriving in RD_WAIT/TX_HOLD fall through untouched: no case below consumes them.
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = (state_d != IDLE);
`ifdef RD_TIMEOUT_EN
    err_timeout_d = 1'b0;
`endif
    case (state_q)
      WR_ADDR: begin
        if (rx_valid) rf_addr_d = rx_data[ADDR_W-1:0];
      end
      WR_DATA: begin
        if (rx_valid) begin
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
        end
      end
      RD_ADDR: begin
        if (rx_valid) begin
          rf_addr_d  = rx_data[ADDR_W-1:0];
          rf_rd_en_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (rf_rd_valid) begin
          tx_data_d  = rf_rd_data;
          tx_valid_d = 1'b1;
        end
`ifdef RD_TIMEOUT_EN
        else if (rd_expired) begin
          err_timeout_d = 1'b1;
        end
`endif
      end
      TX_HOLD: begin
        if (tx_ready) tx_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
    end
  end

`ifdef RD_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed self-checking bench for reg_cmd_ctrl with a small register-file read model.
module tb_reg_cmd_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic [7:0] rf_rd_data;
  logic       rf_rd_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       err_timeout;

  int vec_count = 0;
  int err_count = 0;

  logic [7:0] model_mem [16];
  logic       withhold;
  logic       pend;
  int         wr_count = 0;
  int         rd_count = 0;
  int         tx_count = 0;
  logic       overlap = 1'b0;

  reg_cmd_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rf_wr_en    (rf_wr_en),
    .rf_rd_en    (rf_rd_en),
    .rf_addr     (rf_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_rd_data  (rf_rd_data),
    .rf_rd_valid (rf_rd_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register-file read model: data returns one cycle after rf_rd_en unless withheld.
  always @(posedge CLK) begin
    if (RST) begin
      pend        <= 1'b0;
      rf_rd_valid <= 1'b0;
    end else begin
      rf_rd_valid <= 1'b0;
      if ((rf_rd_en || pend) && !withhold) begin
        rf_rd_valid <= 1'b1;
        pend        <= 1'b0;
      end else if (rf_rd_en) begin
        pend <= 1'b1;
      end
    end
    rf_rd_data <= model_mem[rf_addr];
  end

  always @(posedge CLK) begin
    if (rf_wr_en) wr_count <= wr_count + 1;
    if (rf_rd_en) rd_count <= rd_count + 1;
    if (tx_valid && tx_ready) tx_count <= tx_count + 1;
    if (rf_wr_en && rf_rd_en) overlap <= 1'b1;
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    vec_count++; if (rf_wr_en !== 1'b0) begin err_count++; $display("[TB] FAIL reset_wr_en: got %b expected 0", rf_wr_en); end
    vec_count++; if (rf_rd_en !== 1'b0) begin err_count++; $display("[TB] FAIL reset_rd_en: got %b expected 0", rf_rd_en); end
    vec_count++; if (rf_addr !== 4'h0) begin err_count++; $display("[TB] FAIL reset_addr: got %h expected 0", rf_addr); end
    vec_count++; if (rf_wr_data !== 8'h00) begin err_count++; $display("[TB] FAIL reset_wr_data: got %h expected 00", rf_wr_data); end
    vec_count++; if (tx_data !== 8'h00) begin err_count++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    vec_count++; if (tx_valid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vec_count++; if (err_timeout !== 1'b0) begin err_count++; $display("[TB] FAIL reset_err_timeout: got %b expected 0", err_timeout); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int base;
    base = wr_count;
    send_byte(8'hAA);
    vec_count++; if (busy !== 1'b1) begin err_count++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
    send_byte(8'h05);
    vec_count++; if (rf_wr_en !== 1'b0) begin err_count++; $display("[TB] FAIL write_early_strobe: got %b expected 0", rf_wr_en); end
    send_byte(8'h3C);
    vec_count++; if (rf_wr_en !== 1'b1) begin err_count++; $display("[TB] FAIL write_strobe: got %b expected 1", rf_wr_en); end
    vec_count++; if (rf_addr !== 4'h5) begin err_count++; $display("[TB] FAIL write_addr: got %h expected 5", rf_addr); end
    vec_count++; if (rf_wr_data !== 8'h3C) begin err_count++; $display("[TB] FAIL write_data: got %h expected 3c", rf_wr_data); end
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("[TB] FAIL write_done_busy: got %b expected 0", busy); end
    tick();
    vec_count++; if (rf_wr_en !== 1'b0) begin err_count++; $display("[TB] FAIL write_strobe_len: got %b expected 0", rf_wr_en); end
    vec_count++; if (wr_count - base !== 1) begin err_count++; $display("[TB] FAIL write_count: got %0d expected 1", wr_count - base); end
  endtask

  task automatic test_read();
    int tx_base;
    tx_base = tx_count;
    model_mem[2] = 8'h81;
    send_byte(8'hBB);
    send_byte(8'h02);
    vec_count++; if (rf_rd_en !== 1'b1) begin err_count++; $display("[TB] FAIL read_strobe: got %b expected 1", rf_rd_en); end
    vec_count++; if (rf_addr !== 4'h2) begin err_count++; $display("[TB] FAIL read_addr: got %h expected 2", rf_addr); end
    tick();
    vec_count++; if (rf_rd_en !== 1'b0) begin err_count++; $display("[TB] FAIL read_strobe_len: got %b expected 0", rf_rd_en); end
    tick();
    vec_count++; if (tx_valid !== 1'b1) begin err_count++; $display("[TB] FAIL read_tx_valid: got %b expected 1", tx_valid); end
    vec_count++; if (tx_data !== 8'h81) begin err_count++; $display("[TB] FAIL read_tx_data: got %h expected 81", tx_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_count++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h81) begin
        err_count++; $display("[TB] FAIL read_hold%0d: got valid=%b data=%h expected valid=1 data=81", i, tx_valid, tx_data);
      end
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    vec_count++; if (tx_valid !== 1'b0) begin err_count++; $display("[TB] FAIL read_release: got %b expected 0", tx_valid); end
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("[TB] FAIL read_done_busy: got %b expected 0", busy); end
    vec_count++; if (tx_count - tx_base !== 1) begin err_count++; $display("[TB] FAIL read_tx_count: got %0d expected 1", tx_count - tx_base); end
  endtask

  task automatic test_junk();
    int base;
    base = wr_count;
    send_byte(8'h11);
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("[TB] FAIL junk_busy: got %b expected 0", busy); end
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'hFF);
    vec_count++; if (rf_wr_en !== 1'b1 || rf_addr !== 4'h7 || rf_wr_data !== 8'hFF) begin
      err_count++; $display("[TB] FAIL junk_write: got en=%b addr=%h data=%h expected en=1 addr=7 data=ff", rf_wr_en, rf_addr, rf_wr_data);
    end
    tick();
    vec_count++; if (wr_count - base !== 1) begin err_count++; $display("[TB] FAIL junk_count: got %0d expected 1", wr_count - base); end
  endtask

  task automatic test_addr_mask();
    send_byte(8'hAA);
    send_byte(8'hE9);
    send_byte(8'h12);
    vec_count++; if (rf_wr_en !== 1'b1 || rf_addr !== 4'h9 || rf_wr_data !== 8'h12) begin
      err_count++; $display("[TB] FAIL addr_mask: got en=%b addr=%h data=%h expected en=1 addr=9 data=12", rf_wr_en, rf_addr, rf_wr_data);
    end
    tick();
  endtask

  task automatic test_drop();
    int wr_base;
    int tx_base;
    wr_base = wr_count;
    tx_base = tx_count;
    model_mem[3] = 8'h5A;
    withhold = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'h01);
    withhold = 1'b0;
    tick();
    tick();
    vec_count++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
      err_count++; $display("[TB] FAIL drop_tx: got valid=%b data=%h expected valid=1 data=5a", tx_valid, tx_data);
    end
    send_byte(8'h02);
    vec_count++; if (tx_valid !== 1'b1) begin err_count++; $display("[TB] FAIL drop_hold: got %b expected 1", tx_valid); end
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    tx_ready = 1'b1;
    tick();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    vec_count++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      err_count++; $display("[TB] FAIL drop_exit: got valid=%b busy=%b expected valid=0 busy=0", tx_valid, busy);
    end
    tick();
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("[TB] FAIL drop_same_cycle_byte: got busy=%b expected 0", busy); end
    vec_count++; if (wr_count - wr_base !== 0) begin err_count++; $display("[TB] FAIL drop_no_write: got %0d expected 0", wr_count - wr_base); end
    vec_count++; if (tx_count - tx_base !== 1) begin err_count++; $display("[TB] FAIL drop_tx_count: got %0d expected 1", tx_count - tx_base); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = wr_count;
    send_byte(8'hAA);
    send_byte(8'h04);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vec_count++; if (rf_addr !== 4'h0 || busy !== 1'b0) begin
      err_count++; $display("[TB] FAIL midreset_state: got addr=%h busy=%b expected addr=0 busy=0", rf_addr, busy);
    end
    send_byte(8'h99);
    tick();
    vec_count++; if (wr_count - base !== 0) begin err_count++; $display("[TB] FAIL midreset_no_write: got %0d expected 0", wr_count - base); end
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
  endtask

`ifdef RD_TIMEOUT_EN
  task automatic test_timeout();
    int base;
    withhold = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h04);
    for (int i = 1; i < 16; i++) begin
      tick();
      vec_count++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
        err_count++; $display("[TB] FAIL timeout_early%0d: got err=%b busy=%b expected err=0 busy=1", i, err_timeout, busy);
      end
    end
    tick();
    vec_count++; if (err_timeout !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      err_count++; $display("[TB] FAIL timeout_fire: got err=%b valid=%b busy=%b expected err=1 valid=0 busy=0", err_timeout, tx_valid, busy);
    end
    tick();
    vec_count++; if (err_timeout !== 1'b0) begin err_count++; $display("[TB] FAIL timeout_pulse_len: got %b expected 0", err_timeout); end
    withhold = 1'b0;
    tick();
    base = wr_count;
    send_byte(8'hAA);
    send_byte(8'h0C);
    send_byte(8'h77);
    vec_count++; if (rf_wr_en !== 1'b1 || rf_addr !== 4'hC || rf_wr_data !== 8'h77) begin
      err_count++; $display("[TB] FAIL timeout_next_frame: got en=%b addr=%h data=%h expected en=1 addr=c data=77", rf_wr_en, rf_addr, rf_wr_data);
    end
    tick();
    vec_count++; if (wr_count - base !== 1 || tx_valid !== 1'b0) begin
      err_count++; $display("[TB] FAIL timeout_after: got writes=%0d valid=%b expected writes=1 valid=0", wr_count - base, tx_valid);
    end
  endtask
`else
  task automatic test_no_timeout();
    withhold = 1'b1;
    model_mem[4] = 8'hC7;
    send_byte(8'hBB);
    send_byte(8'h04);
    repeat (24) tick();
    vec_count++; if (busy !== 1'b1 || err_timeout !== 1'b0 || tx_valid !== 1'b0) begin
      err_count++; $display("[TB] FAIL wait_forever: got busy=%b err=%b valid=%b expected busy=1 err=0 valid=0", busy, err_timeout, tx_valid);
    end
    withhold = 1'b0;
    tick();
    tick();
    vec_count++; if (tx_valid !== 1'b1 || tx_data !== 8'hC7) begin
      err_count++; $display("[TB] FAIL late_read: got valid=%b data=%h expected valid=1 data=c7", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    vec_count++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      err_count++; $display("[TB] FAIL late_release: got valid=%b busy=%b expected valid=0 busy=0", tx_valid, busy);
    end
  endtask
`endif

  initial begin
    RST      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    withhold = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'(i * 16 + i);
    test_reset();
    test_write();
    test_read();
    test_junk();
    test_addr_mask();
    test_drop();
    test_reset_mid();
`ifdef RD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    vec_count++; if (overlap !== 1'b0) begin err_count++; $display("[TB] FAIL strobe_overlap: got %b expected 0", overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
